loop_uhat_pipe_mac: RTL and testbench
=====================================

// Module: loop_uhat_pipe_mac
// PURPOSE
//  Parametrised pipelined multiply / multiply-accumulate for the loop_uhat datapath; next generation of the fixed-latency mul cores.
//  Adds per-sample signedness, a valid pipeline, sync reset, optional running accumulation and configurable depth.
//  Sits between loop_uhat operand fetch and the sparse result writer.
//  A ce-gated stall freezes the whole pipe.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  NUM_STAGE   5   latency in ce-cycles, legal range 2..8
//  din0_WIDTH  73  operand A width
//  din1_WIDTH  6   operand B width
//  dout_WIDTH  79  result/accumulator width, >= 2
// PORTS
//  clk       in   1           clock, all logic on rising edge
//  reset     in   1           synchronous, active-high; one clock; polarity/synchronicity fixed
//  ce        in   1           clock enable; 0 = whole pipe holds state
//  din_vld   in   1           input sample valid
//  din0      in   din0_WIDTH  operand A
//  din1      in   din1_WIDTH  operand B
//  din0_sgn  in   1           1 = din0 is two's complement, 0 = unsigned
//  din1_sgn  in   1           1 = din1 is two's complement, 0 = unsigned
//  din_first in   1           1 = sample starts a new sum (plain mul: tie 1)
//  dout      out  dout_WIDTH  result / running sum
//  dout_vld  out  1           1-cycle pulse per result (while ce=1)
// BEHAVIOUR
//  - Reset priority over ce: dout=0, dout_vld=0, all valid bits=0, acc=0. Operand/product data regs not reset.
//  - ce=1: every stage advances, bubbles included; ce=0: all regs incl. valid bits and dout_vld hold.
//  - Latency: sample with din_vld=1 on ce-cycle k appears on dout/dout_vld at ce-cycle k+NUM_STAGE.
//  - Stage 1: register din0/din1/sign flags/din_first/din_vld.
//  - Operands extended by 1 bit: sign bit if *_sgn, else 0.
//  - Product: signed, width P = din0_WIDTH+din1_WIDTH+2, exact.
//  - Stages 2..NUM_STAGE-1: product retiming registers.
//  - For NUM_STAGE=2: product formed combinationally between stage 1 and the final stage.
//  - Final stage, when valid: din_first=1 -> acc <= prod; else acc <= acc + prod.
//  - P > dout_WIDTH: prod truncated to low dout_WIDTH bits. P < dout_WIDTH: prod sign-extended.
//  - Sum wraps modulo 2^dout_WIDTH; no saturation, no overflow flag.
//  - Final stage not valid: acc holds, dout_vld=0.
//  - dout = acc register; stable between valid pulses.
//  - Back-to-back valid samples: one result per ce-cycle, no stall.
//  - Reset mid-stream: all in-flight samples discarded, no dout_vld after reset until new input.
//  - Accumulating sample after reset without preceding din_first=1: adds into acc=0; legal.
//  - Illegal NUM_STAGE: elaboration error via generate-time check.
// STRUCTURE
//  - Shared package loop_uhat_pkg: LOOP_UHAT_MAC_MIN_STAGE=2, LOOP_UHAT_MAC_MAX_STAGE=8, prod_width function (a+b+2).
//  - Sub-module loop_uhat_pipe_dly: parametrised (WIDTH, DEPTH) ce-gated shift register.
//    - Reset clears only the valid lane.
//    - Carries product + first + vld.
//  - Top holds operand extension, multiplier expression and accumulator.
// TESTING
//  - din0_WIDTH=8, din1_WIDTH=4, dout_WIDTH=16, NUM_STAGE=5 unless noted; scoreboard vs ref model.
//  1 Unsigned mul: A=255,B=15,sgn=00,first=1 -> dout=3825 exactly 5 ce-cycles later, dout_vld one pulse.
//  2 Signed mul: A=0x80(-128),B=0x7(7),sgn=11 -> dout=0xFC80 (-896).
//    Same data with sgn=01 -> 128*7=896.
//  3 Accumulate: (3,4,first=1),(5,6,0),(-2,2 signed,0) back-to-back.
//    -> three pulses on consecutive cycles: 12, 42, 38.
//  4 Stall: ce low 3 cycles mid-stream -> results unchanged; arrival delayed by exactly 3; no extra/lost pulses.
//  5 Reset with 3 samples in flight -> dout=0, dout_vld=0 next cycle; no pulses thereafter.
//  6 Wrap: dout_WIDTH=8, acc sums 200+100 -> dout=44.
//    Sweep NUM_STAGE=2 and 8; latency matches parameter.

Source files
------------

// File: rtl/loop_uhat_pkg.sv
// Shared definitions for the loop_uhat datapath.
//   LOOP_UHAT_MAC_MIN_STAGE / LOOP_UHAT_MAC_MAX_STAGE : legal latency range of the MAC pipe
//   prod_width()                                      : exact signed product width for
//                                                       operands extended by one bit each
package loop_uhat_pkg;

   localparam int unsigned LOOP_UHAT_MAC_MIN_STAGE = 2;
   localparam int unsigned LOOP_UHAT_MAC_MAX_STAGE = 8;

   // Both operands gain a sign/zero bit, so the exact product needs a + b + 2 bits.
   function automatic int unsigned prod_width(input int unsigned a_width,
                                              input int unsigned b_width);
      return a_width + b_width + 2;
   endfunction

endpackage

// File: rtl/loop_uhat_pipe_dly.sv
// Clock-enable gated shift register used to retime the MAC product.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high; clears only the valid lane
//   ce      clock enable; 0 freezes every stage (data and valid)
//   data_i  data entering stage 0          data_o  data leaving stage DEPTH-1
//   vld_i   valid entering stage 0         vld_o   valid leaving stage DEPTH-1
module loop_uhat_pipe_dly #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [WIDTH-1:0] data_i,
   input  logic             vld_i,
   output logic [WIDTH-1:0] data_o,
   output logic             vld_o
);

   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]            vld_q, vld_d;

   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (ce) begin
         data_d[0] = data_i;
         vld_d[0]  = vld_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
      end
   end

   // Data lanes are intentionally not reset; the valid lane qualifies them.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign data_o = data_q[DEPTH-1];
   assign vld_o  = vld_q[DEPTH-1];

endmodule

// File: rtl/loop_uhat_pipe_mac.sv
// Pipelined multiply / multiply-accumulate for the loop_uhat datapath.
// A sample with din_vld=1 on ce-cycle k shows up on dout/dout_vld on ce-cycle k+NUM_STAGE.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset (priority over ce)
//   ce               clock enable; 0 holds every register including valid bits and dout_vld
//   din_vld          input sample valid
//   din0, din1       operands A and B
//   din0_sgn/_sgn    1 = operand is two's complement, 0 = unsigned
//   din_first        1 = sample starts a new sum, 0 = add into the running sum
//   dout             accumulator register (result / running sum)
//   dout_vld         one pulse per result
module loop_uhat_pipe_mac
   import loop_uhat_pkg::*;
#(
   parameter int          ID         = 1,
   parameter int unsigned NUM_STAGE  = 5,
   parameter int unsigned din0_WIDTH = 73,
   parameter int unsigned din1_WIDTH = 6,
   parameter int unsigned dout_WIDTH = 79
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  din_vld,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  din0_sgn,
   input  logic                  din1_sgn,
   input  logic                  din_first,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  dout_vld
);

   localparam int unsigned P      = prod_width(din0_WIDTH, din1_WIDTH);
   localparam int unsigned LANE_W = dout_WIDTH + 1;

   if (ID < 0 || NUM_STAGE < LOOP_UHAT_MAC_MIN_STAGE || NUM_STAGE > LOOP_UHAT_MAC_MAX_STAGE ||
       dout_WIDTH < 2) begin : g_bad_param
      $error("loop_uhat_pipe_mac ID=%0d: illegal NUM_STAGE=%0d or dout_WIDTH=%0d",
             ID, NUM_STAGE, dout_WIDTH);
   end

   // ---------------- Stage 1: input registers ----------------
   logic [din0_WIDTH-1:0] a_q, a_d;
   logic [din1_WIDTH-1:0] b_q, b_d;
   logic                  a_sgn_q, a_sgn_d;
   logic                  b_sgn_q, b_sgn_d;
   logic                  s1_first_q, s1_first_d;
   logic                  s1_vld_q, s1_vld_d;

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      a_sgn_d    = a_sgn_q;
      b_sgn_d    = b_sgn_q;
      s1_first_d = s1_first_q;
      s1_vld_d   = s1_vld_q;
      if (ce) begin
         a_d        = din0;
         b_d        = din1;
         a_sgn_d    = din0_sgn;
         b_sgn_d    = din1_sgn;
         s1_first_d = din_first;
         s1_vld_d   = din_vld;
      end
   end

   always_ff @(posedge clk) begin
      a_q        <= a_d;
      b_q        <= b_d;
      a_sgn_q    <= a_sgn_d;
      b_sgn_q    <= b_sgn_d;
      s1_first_q <= s1_first_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
      end
   end

   // ---------------- Multiplier ----------------
   logic                 a_msb, b_msb;
   logic signed [P-1:0]  a_wide, b_wide;
   logic [dout_WIDTH-1:0] prod_fit;

   // Each operand is extended to the full product width using its own sign bit (or zero),
   // so a single signed multiply covers all four signedness combinations exactly.
   // The width cast keeps the low dout_WIDTH bits when P is wider and sign-extends when
   // P is narrower.
   always_comb begin
      a_msb    = a_sgn_q & a_q[din0_WIDTH-1];
      b_msb    = b_sgn_q & b_q[din1_WIDTH-1];
      a_wide   = {{(din1_WIDTH + 2){a_msb}}, a_q};
      b_wide   = {{(din0_WIDTH + 2){b_msb}}, b_q};
      prod_fit = dout_WIDTH'(a_wide * b_wide);
   end

   // ---------------- Retiming stages 2..NUM_STAGE-1 ----------------
   logic [LANE_W-1:0] fin_data;
   logic              fin_vld;

   if (NUM_STAGE > 2) begin : g_dly
      loop_uhat_pipe_dly #(
         .WIDTH (LANE_W),
         .DEPTH (NUM_STAGE - 2)
      ) u_dly (
         .clk    (clk),
         .reset  (reset),
         .ce     (ce),
         .data_i ({prod_fit, s1_first_q}),
         .vld_i  (s1_vld_q),
         .data_o (fin_data),
         .vld_o  (fin_vld)
      );
   end else begin : g_no_dly
      // Two-stage pipe: product goes straight from stage 1 into the accumulator.
      assign fin_data = {prod_fit, s1_first_q};
      assign fin_vld  = s1_vld_q;
   end

   // ---------------- Final stage: accumulator ----------------
   logic [dout_WIDTH-1:0] fin_prod;
   logic                  fin_first;
   logic [dout_WIDTH-1:0] acc_q, acc_d;
   logic                  dout_vld_q, dout_vld_d;

   assign fin_prod  = fin_data[LANE_W-1:1];
   assign fin_first = fin_data[0];

   always_comb begin
      acc_d      = acc_q;
      dout_vld_d = dout_vld_q;
      if (ce) begin
         dout_vld_d = fin_vld;
         if (fin_vld) begin
            acc_d = fin_first ? fin_prod : acc_q + fin_prod;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q      <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   assign dout     = acc_q;
   assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_loop_uhat_pipe_mac.sv
// Directed bench for loop_uhat_pipe_mac. Four instances share one stimulus stream:
//   idx 0 "m"  : 8x4 -> 16, NUM_STAGE=5 (main)
//   idx 1 "w"  : 8x4 -> 8,  NUM_STAGE=5 (wrap / truncation)
//   idx 2 "s2" : 8x4 -> 16, NUM_STAGE=2
//   idx 3 "s8" : 8x4 -> 16, NUM_STAGE=8
module tb_loop_uhat_pipe_mac;

   logic       clk = 1'b0;
   logic       reset, ce, din_vld, din0_sgn, din1_sgn, din_first;
   logic [7:0] din0;
   logic [3:0] din1;

   logic [15:0] dout_m, dout_2, dout_8;
   logic [7:0]  dout_w;
   logic        dout_vld_m, dout_vld_w, dout_vld_2, dout_vld_8;

   always #5 clk = ~clk;

   loop_uhat_pipe_mac #(.ID(0), .NUM_STAGE(5), .din0_WIDTH(8), .din1_WIDTH(4), .dout_WIDTH(16))
   u_dut_m (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .din0_sgn(din0_sgn), .din1_sgn(din1_sgn), .din_first(din_first),
      .dout(dout_m), .dout_vld(dout_vld_m)
   );

   loop_uhat_pipe_mac #(.ID(1), .NUM_STAGE(5), .din0_WIDTH(8), .din1_WIDTH(4), .dout_WIDTH(8))
   u_dut_w (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .din0_sgn(din0_sgn), .din1_sgn(din1_sgn), .din_first(din_first),
      .dout(dout_w), .dout_vld(dout_vld_w)
   );

   loop_uhat_pipe_mac #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(4), .dout_WIDTH(16))
   u_dut_2 (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .din0_sgn(din0_sgn), .din1_sgn(din1_sgn), .din_first(din_first),
      .dout(dout_2), .dout_vld(dout_vld_2)
   );

   loop_uhat_pipe_mac #(.ID(3), .NUM_STAGE(8), .din0_WIDTH(8), .din1_WIDTH(4), .dout_WIDTH(16))
   u_dut_8 (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .din0_sgn(din0_sgn), .din1_sgn(din1_sgn), .din_first(din_first),
      .dout(dout_8), .dout_vld(dout_vld_8)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int c0     = 0;

   // Main instance: every pulse with its cycle. Others: pulse count, first cycle, last value.
   logic [15:0] got_v[$];
   int          got_c[$];
   int          cnt [4];
   int          fc  [4];
   logic [15:0] lv  [4];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic rec(input int idx, input logic v, input logic [15:0] d);
      if (v) begin
         if (cnt[idx] == 0) fc[idx] = cyc;
         cnt[idx]++;
         lv[idx] = d;
      end
   endtask

   task automatic clear_rec();
      got_v.delete();
      got_c.delete();
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         fc[i]  = -1;
         lv[i]  = 16'h0;
      end
      c0 = cyc;
   endtask

   // A pulse is only counted if ce was high at the edge that produced it.
   task automatic tick();
      logic ce_e;
      ce_e = ce;
      @(posedge clk);
      #1;
      cyc++;
      if (ce_e && dout_vld_m) begin
         got_v.push_back(dout_m);
         got_c.push_back(cyc);
      end
      rec(0, ce_e & dout_vld_m, dout_m);
      rec(1, ce_e & dout_vld_w, {8'h00, dout_w});
      rec(2, ce_e & dout_vld_2, dout_2);
      rec(3, ce_e & dout_vld_8, dout_8);
   endtask

   task automatic push(input logic [7:0] a, input logic [3:0] b, input logic sa, input logic sb,
                       input logic f);
      din_vld   = 1'b1;
      din0      = a;
      din1      = b;
      din0_sgn  = sa;
      din1_sgn  = sb;
      din_first = f;
      tick();
   endtask

   task automatic idle(input int n);
      din_vld = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [31:0] qv(input int i);
      if (i < got_v.size()) return {16'h0, got_v[i]};
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] qc(input int i);
      if (i < got_c.size()) return got_c[i] - c0;
      return 32'hFFFF_FFFF;
   endfunction

   initial begin
      reset = 1'b1; ce = 1'b1; din_vld = 1'b0; din0 = '0; din1 = '0;
      din0_sgn = 1'b0; din1_sgn = 1'b0; din_first = 1'b1;
      clear_rec();
      idle(2);
      reset = 1'b0;
      check_eq("rst dout_m", dout_m, 0);
      check_eq("rst vld_m", dout_vld_m, 0);
      check_eq("rst dout_w", dout_w, 0);
      check_eq("rst dout_8", dout_8, 0);
      check_eq("rst vld_2", dout_vld_2, 0);

      // 1: unsigned 255*15, latency of all three depths
      clear_rec();
      push(8'd255, 4'd15, 1'b0, 1'b0, 1'b1);
      idle(11);
      check_eq("t1 pulses", got_v.size(), 1);
      check_eq("t1 val", qv(0), 3825);
      check_eq("t1 lat5", qc(0), 5);
      check_eq("t1 hold", dout_m, 3825);
      check_eq("t1 w trunc", lv[1], 241);
      check_eq("t1 lat2", fc[2] - c0, 2);
      check_eq("t1 lat8", fc[3] - c0, 8);
      check_eq("t1 s8 pulses", cnt[3], 1);

      // 2: signed -128*7, then unsigned-A 128*7
      clear_rec();
      push(8'h80, 4'h7, 1'b1, 1'b1, 1'b1);
      push(8'h80, 4'h7, 1'b0, 1'b1, 1'b1);
      idle(10);
      check_eq("t2 pulses", got_v.size(), 2);
      check_eq("t2 signed", qv(0), 16'hFC80);
      check_eq("t2 mixed", qv(1), 896);
      check_eq("t2 cyc0", qc(0), 5);
      check_eq("t2 cyc1", qc(1), 6);
      check_eq("t2 s8 last", lv[3], 896);

      // 3: back-to-back accumulation 12, 42, 38
      clear_rec();
      push(8'd3, 4'd4, 1'b0, 1'b0, 1'b1);
      push(8'd5, 4'd6, 1'b0, 1'b0, 1'b0);
      push(8'hFE, 4'd2, 1'b1, 1'b1, 1'b0);
      idle(10);
      check_eq("t3 pulses", got_v.size(), 3);
      check_eq("t3 v0", qv(0), 12);
      check_eq("t3 v1", qv(1), 42);
      check_eq("t3 v2", qv(2), 38);
      check_eq("t3 c0", qc(0), 5);
      check_eq("t3 c2", qc(2), 7);
      check_eq("t3 s2 pulses", cnt[2], 3);
      check_eq("t3 s2 last", lv[2], 38);
      check_eq("t3 s8 last", lv[3], 38);

      // 4: three-cycle stall mid-stream; inputs during the stall must be ignored
      clear_rec();
      push(8'd3, 4'd4, 1'b0, 1'b0, 1'b1);
      push(8'd5, 4'd6, 1'b0, 1'b0, 1'b0);
      ce = 1'b0;
      push(8'd99, 4'd9, 1'b0, 1'b0, 1'b1);
      push(8'd99, 4'd9, 1'b0, 1'b0, 1'b1);
      push(8'd99, 4'd9, 1'b0, 1'b0, 1'b1);
      ce = 1'b1;
      push(8'hFE, 4'd2, 1'b1, 1'b1, 1'b0);
      idle(10);
      check_eq("t4 pulses", got_v.size(), 3);
      check_eq("t4 v0", qv(0), 12);
      check_eq("t4 v1", qv(1), 42);
      check_eq("t4 v2", qv(2), 38);
      check_eq("t4 c0", qc(0), 8);
      check_eq("t4 c1", qc(1), 9);
      check_eq("t4 c2", qc(2), 10);

      // 5: reset (with ce low) while three samples are in flight
      push(8'd7, 4'd7, 1'b0, 1'b0, 1'b1);
      push(8'd1, 4'd1, 1'b0, 1'b0, 1'b1);
      push(8'd2, 4'd2, 1'b0, 1'b0, 1'b1);
      clear_rec();
      din_vld = 1'b0;
      reset   = 1'b1;
      ce      = 1'b0;
      tick();
      reset = 1'b0;
      ce    = 1'b1;
      check_eq("t5 dout", dout_m, 0);
      check_eq("t5 vld", dout_vld_m, 0);
      check_eq("t5 dout_8", dout_8, 0);
      idle(12);
      check_eq("t5 no pulses m", got_v.size(), 0);
      check_eq("t5 no pulses s2", cnt[2], 0);
      check_eq("t5 no pulses s8", cnt[3], 0);

      // accumulate without a preceding first after reset: adds into zero
      clear_rec();
      push(8'd5, 4'd5, 1'b0, 1'b0, 1'b0);
      idle(8);
      check_eq("t5 acc0 val", qv(0), 25);
      check_eq("t5 acc0 cyc", qc(0), 5);

      // 6: 200 + 100 wraps to 44 in the 8-bit instance
      clear_rec();
      push(8'd200, 4'd1, 1'b0, 1'b0, 1'b1);
      push(8'd100, 4'd1, 1'b0, 1'b0, 1'b0);
      idle(8);
      check_eq("t6 w pulses", cnt[1], 2);
      check_eq("t6 w wrap", lv[1], 44);
      check_eq("t6 m sum", qv(1), 300);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
